// File: rtl/pll_lock_sequencer_if.sv
// Sequencer-to-PLL/system bundle: PLL handshake, restart request and status.
// The sequencer is the master; the PLL wrapper or system controller is the slave.
interface pll_lock_sequencer_if;
   logic       pll_locked;
   logic       restart;
   logic       pll_rst;
   logic       core_reset_n;
   logic       ready;
   logic       lock_lost;
   logic       fault;
   logic [7:0] retry_count;
   logic [2:0] state;

   modport master (
      input  pll_locked, restart,
      output pll_rst, core_reset_n, ready, lock_lost, fault, retry_count, state
   );

   modport slave (
      output pll_locked, restart,
      input  pll_rst, core_reset_n, ready, lock_lost, fault, retry_count, state
   );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses PLL reset, waits for lock with a timeout and retries,
// qualifies lock as stable, then releases the core reset.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | one cycle after reset, PLL held in reset
// RESET     | pll_rst high for RST_PULSE_CYCLES
// WAIT_LOCK | waiting for synchronized lock, bounded by LOCK_TIMEOUT_CYCLES
// STABLE    | counting consecutive locked cycles before release
// RUN       | core reset released, ready high
// FAULT     | too many consecutive timeouts, waiting for restart
module pll_lock_sequencer #(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 74250,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int MAX_RETRIES         = 3
) (
   input logic                   clk_74a,
   input logic                   reset_n,
   pll_lock_sequencer_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RESET     = 3'd1,
      S_WAIT_LOCK = 3'd2,
      S_STABLE    = 3'd3,
      S_RUN       = 3'd4,
      S_FAULT     = 3'd5
   } state_t;

   // One shared down-counter serves all three timed states; each state loads it on entry.
   localparam logic [23:0] RST_LOAD     = 24'(RST_PULSE_CYCLES - 1);
   localparam logic [23:0] TIMEOUT_LOAD = 24'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [23:0] STABLE_LOAD  = 24'(LOCK_STABLE_CYCLES - 1);
   localparam logic [7:0]  RETRY_LIMIT  = 8'(MAX_RETRIES);

   state_t      state_q, state_d;
   logic [23:0] timer_q, timer_d;
   logic [7:0]  retry_q, retry_d, retry_inc;
   logic        lk_meta, lk;
   logic        lock_lost_d;
   logic        pll_rst_q, core_reset_n_q, ready_q, lock_lost_q, fault_q;

   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         lk_meta <= 1'b0;
         lk      <= 1'b0;
      end else begin
         lk_meta <= bus.pll_locked;
         lk      <= lk_meta;
      end
   end

   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= S_IDLE;
         timer_q        <= '0;
         retry_q        <= '0;
         pll_rst_q      <= 1'b1;
         core_reset_n_q <= 1'b0;
         ready_q        <= 1'b0;
         lock_lost_q    <= 1'b0;
         fault_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         retry_q        <= retry_d;
         pll_rst_q      <= (state_d == S_IDLE) || (state_d == S_RESET);
         core_reset_n_q <= (state_d == S_RUN);
         ready_q        <= (state_d == S_RUN);
         lock_lost_q    <= lock_lost_d;
         fault_q        <= (state_d == S_FAULT);
      end
   end

   assign retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      retry_d     = retry_q;
      lock_lost_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            state_d = S_RESET;
            timer_d = RST_LOAD;
         end
         S_RESET: begin
            if (timer_q == '0) begin
               state_d = S_WAIT_LOCK;
               timer_d = TIMEOUT_LOAD;
            end else begin
               timer_d = timer_q - 24'd1;
            end
         end
         S_WAIT_LOCK: begin
            // Lock is tested first so a lock on the final timeout cycle is not a retry.
            if (lk) begin
               state_d = S_STABLE;
               timer_d = STABLE_LOAD;
            end else if (timer_q == '0) begin
               retry_d = retry_inc;
               state_d = (retry_inc >= RETRY_LIMIT) ? S_FAULT : S_RESET;
               timer_d = RST_LOAD;
            end else begin
               timer_d = timer_q - 24'd1;
            end
         end
         S_STABLE: begin
            if (!lk) begin
               state_d = S_WAIT_LOCK;
               timer_d = TIMEOUT_LOAD;
            end else if (timer_q == '0) begin
               state_d = S_RUN;
               retry_d = '0;
            end else begin
               timer_d = timer_q - 24'd1;
            end
         end
         S_RUN: begin
            if (!lk) begin
               state_d     = S_RESET;
               timer_d     = RST_LOAD;
               lock_lost_d = 1'b1;
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // A restart overrides everything, including a simultaneous lock loss in RUN.
      if (bus.restart && (state_q != S_IDLE)) begin
         state_d     = S_RESET;
         timer_d     = RST_LOAD;
         retry_d     = '0;
         lock_lost_d = 1'b0;
      end
   end

   assign bus.pll_rst      = pll_rst_q;
   assign bus.core_reset_n = core_reset_n_q;
   assign bus.ready        = ready_q;
   assign bus.lock_lost    = lock_lost_q;
   assign bus.fault        = fault_q;
   assign bus.retry_count  = retry_q;
   assign bus.state        = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small parameters (4/100/8/3).
// Expected values are queued as each step is driven and popped when the DUT is sampled.
module tb_pll_lock_sequencer;
   localparam int RPC = 4;
   localparam int LTC = 100;
   localparam int LSC = 8;
   localparam int MR  = 3;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   pll_lock_sequencer_if bus();

   pll_lock_sequencer #(
      .RST_PULSE_CYCLES   (RPC),
      .LOCK_TIMEOUT_CYCLES(LTC),
      .LOCK_STABLE_CYCLES (LSC),
      .MAX_RETRIES        (MR)
   ) dut (
      .clk_74a(clk),
      .reset_n(reset_n),
      .bus    (bus.master)
   );

   typedef struct {
      string tag;
      int    val;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic void push(input string tag, input int val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endfunction

   task automatic check(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $error("FAIL sb_empty observed=%0d expected=none", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === 32'(e.val))
         else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_all(input string tag, input int st, input int prst, input int crn,
                             input int rdy, input int ll, input int flt, input int rc);
      push({tag, "_state"}, st);        check(32'(bus.state));
      push({tag, "_pll_rst"}, prst);    check(32'(bus.pll_rst));
      push({tag, "_core_reset_n"}, crn); check(32'(bus.core_reset_n));
      push({tag, "_ready"}, rdy);       check(32'(bus.ready));
      push({tag, "_lock_lost"}, ll);    check(32'(bus.lock_lost));
      push({tag, "_fault"}, flt);       check(32'(bus.fault));
      push({tag, "_retry"}, rc);        check(32'(bus.retry_count));
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, output int n);
      n = 0;
      while (bus.state !== s && n < budget) begin
         step(1);
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         n, n_aux, n_ll, changes;
      logic [7:0] prev_rc;

      reset_n        = 1'b0;
      bus.pll_locked = 1'b0;
      bus.restart    = 1'b0;
      step(3);
      expect_all("rst", 0, 1, 0, 0, 0, 0, 0);

      // Nominal lock
      reset_n = 1'b1;
      n = 0;
      while (bus.pll_rst === 1'b1 && n < 50) begin step(1); n++; end
      push("nom_pll_rst_cycles", RPC + 1);  check(n);
      push("nom_state_wait", 2);            check(32'(bus.state));
      step(10);
      bus.pll_locked = 1'b1;
      n = 0; n_aux = -1;
      while (bus.core_reset_n !== 1'b1 && n < 200) begin
         step(1); n++;
         if (n_aux < 0 && bus.state === 3'd3) n_aux = n;
      end
      push("nom_stable_latency", 3);        check(n_aux);
      push("nom_release_latency", 3 + LSC); check(n);
      push("nom_ready", 1);                 check(32'(bus.ready));
      push("nom_retry", 0);                 check(32'(bus.retry_count));
      push("nom_state_run", 4);             check(32'(bus.state));

      // Loss of lock in RUN
      bus.pll_locked = 1'b0;
      n = 0;
      while (bus.lock_lost !== 1'b1 && n < 20) begin step(1); n++; end
      push("ll_latency", 3);                check(n);
      push("ll_core_reset_n", 0);           check(32'(bus.core_reset_n));
      push("ll_pll_rst", 1);                check(32'(bus.pll_rst));
      push("ll_state", 1);                  check(32'(bus.state));
      bus.pll_locked = 1'b1;
      step(1);
      push("ll_pulse_end", 0);              check(32'(bus.lock_lost));
      n = 1;
      while (bus.ready !== 1'b1 && n < 100) begin step(1); n++; end
      push("ll_resequence_cycles", RPC + 1 + LSC); check(n);

      // Lock glitch in STABLE
      bus.restart = 1'b1; step(1); bus.restart = 1'b0;
      push("gl_restart_state", 1);          check(32'(bus.state));
      wait_state(3'd3, 50, n);
      push("gl_stable_entry", RPC + 1);     check(n);
      step(2);
      bus.pll_locked = 1'b0; step(1); bus.pll_locked = 1'b1;
      step(2);
      push("gl_state_wait", 2);             check(32'(bus.state));
      push("gl_retry", 0);                  check(32'(bus.retry_count));
      step(1);
      push("gl_restable", 3);               check(32'(bus.state));
      n = 0;
      while (bus.core_reset_n !== 1'b1 && n < 100) begin step(1); n++; end
      push("gl_release_cycles", LSC);       check(n);

      // restart on the same cycle lk falls in RUN
      bus.pll_locked = 1'b0;
      step(2);
      bus.restart = 1'b1; step(1); bus.restart = 1'b0;
      push("sim_state", 1);                 check(32'(bus.state));
      push("sim_lock_lost", 0);             check(32'(bus.lock_lost));
      n_ll = 0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         if (bus.lock_lost === 1'b1) n_ll++;
      end
      push("sim_lock_lost_window", 0);      check(n_ll);

      // Timeouts and retries up to FAULT
      for (int k = 1; k <= MR; k++) begin
         push("to_retry_val", k);
         push("to_retry_at", k * (RPC + LTC));
      end
      n = 5; prev_rc = 8'd0; changes = 0;
      while (changes < MR && n < 400) begin
         step(1); n++;
         if (bus.retry_count !== prev_rc) begin
            check(32'(bus.retry_count));
            check(n);
            prev_rc = bus.retry_count;
            changes++;
         end
      end
      while (changes < MR) begin
         check(32'hFFFF_FFFF);
         check(32'hFFFF_FFFF);
         changes++;
      end
      expect_all("fault", 5, 0, 0, 0, 0, 1, MR);
      step(20);
      push("fault_hold_state", 5);          check(32'(bus.state));

      bus.restart = 1'b1; step(1); bus.restart = 1'b0;
      push("fr_state", 1);                  check(32'(bus.state));
      push("fr_fault", 0);                  check(32'(bus.fault));
      push("fr_retry", 0);                  check(32'(bus.retry_count));
      push("fr_pll_rst", 1);                check(32'(bus.pll_rst));

      // lk rises on the final timeout cycle: lock must win
      step(RPC + LTC - 3);
      bus.pll_locked = 1'b1;
      step(2);
      push("edge_state_before", 2);         check(32'(bus.state));
      step(1);
      push("edge_state_after", 3);          check(32'(bus.state));
      push("edge_retry", 0);                check(32'(bus.retry_count));

      // Async reset mid-STABLE, checked before any clock edge
      step(2);
      push("pre_async_state", 3);           check(32'(bus.state));
      #2 reset_n = 1'b0;
      #1;
      expect_all("async", 0, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset_n = 1'b1;
      n = 0; n_aux = -1;
      while (bus.ready !== 1'b1 && n < 100) begin
         step(1); n++;
         if (n_aux < 0 && bus.pll_rst === 1'b0) n_aux = n;
      end
      push("post_pll_rst_cycles", RPC + 1);       check(n_aux);
      push("post_ready_cycles", RPC + 2 + LSC);   check(n);

      checks++;
      assert (exp_q.size() == 0)
      else begin
         failures++;
         $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences the fractional PLL that generates the core video/system clocks from the 74.25 MHz reference.
- Holds the PLL in reset after power-up or a restart request, waits for lock with a timeout, and retries on timeout.
- Qualifies lock as stable before releasing the downstream core reset.
- Re-sequences automatically on loss of lock and latches a fault after repeated failures.

Parameters:
- RST_PULSE_CYCLES, 16: cycles pll_rst is held high per attempt (range 1..65535).
- LOCK_TIMEOUT_CYCLES, 74250: max cycles in WAIT_LOCK before declaring a timeout (1 ms at 74.25 MHz; range 1..2^24-1).
- LOCK_STABLE_CYCLES, 1024: consecutive cycles of synchronized lock required before release (range 1..65535).
- MAX_RETRIES, 3: consecutive timeouts tolerated before FAULT (range 1..255).

Ports:
- clk_74a  in  1  free-running 74.25 MHz reference clock; the only clock in the block.
- reset_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL locked output, asynchronous to clk_74a. Passes through an internal 2-flop synchronizer; the synchronized signal is lk.
- restart  in  1  single-cycle request to re-sequence the PLL. Honoured in every state.
- pll_rst  out  1  PLL reset, active-high.
- core_reset_n  out  1  downstream reset, active-low. Deasserted only in RUN.
- ready  out  1  high in RUN.
- lock_lost  out  1  one-cycle pulse when lk falls while in RUN.
- fault  out  1  high in FAULT.
- retry_count  out  8  consecutive timeout count. Saturates at 255.
- state  out  3  state encoding, for debug: IDLE=0, RESET=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAULT=5.

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE, pll_rst=1, core_reset_n=0, ready=0, lock_lost=0, fault=0, retry_count=0.
  - All counters and synchronizer flops cleared.
  - Reset asserted mid-operation returns to these values immediately.
- All outputs are registered and decoded from state. pll_rst=1 in IDLE and RESET, 0 otherwise.
- IDLE: one cycle, then RESET with the timer loaded.
- RESET: pll_rst=1 for exactly RST_PULSE_CYCLES cycles, then WAIT_LOCK with the timeout timer cleared.
- WAIT_LOCK:
  - lk=1 -> STABLE with the stable counter cleared.
  - Timer reaches LOCK_TIMEOUT_CYCLES-1 with lk=0 -> timeout: retry_count+1 (saturating).
  - On timeout, if the incremented retry_count >= MAX_RETRIES -> FAULT; else -> RESET.
  - lk=1 and timeout in the same cycle: lock wins.
- STABLE:
  - Counts consecutive lk=1 cycles. After LOCK_STABLE_CYCLES cycles -> RUN and retry_count cleared to 0.
  - lk=0 at any point -> WAIT_LOCK with the timeout timer restarted. retry_count unchanged; a glitch is not a timeout.
- RUN:
  - core_reset_n=1, ready=1.
  - lk=0 -> lock_lost pulses for one cycle, then the next state is RESET. core_reset_n=0 and ready=0 on the same registered edge as the transition.
- FAULT: pll_rst=0, core_reset_n=0, fault=1. Held until restart or reset_n.
- restart: in any state except IDLE, next state is RESET; fault and retry_count are cleared.
  - restart and lk falling in RUN in the same cycle: restart wins and lock_lost is not pulsed.
- Latency:
  - pll_locked rise to STABLE entry: 3 cycles (2 sync + 1 registered).
  - Lock-stable release: pll_locked rise to core_reset_n=1 is 3+LOCK_STABLE_CYCLES cycles.
- Counter widths: at least 16 bits for the RESET and STABLE timers, 24 bits for the timeout timer. No wrap is permitted in any state.

Test Plan:
- Nominal lock (params 4/100/8/3):
  - Stimulus: release reset_n; raise pll_locked 10 cycles after pll_rst falls.
  - Required response: pll_rst high for exactly 5 cycles (IDLE + 4); core_reset_n rises exactly 11 cycles after pll_locked rises; ready=1; retry_count=0.
- Timeout and retry (same params):
  - Stimulus: hold pll_locked=0.
  - Required response: three RESET/WAIT_LOCK cycles of 4+100 cycles each; retry_count goes 1, 2, 3; FAULT entered with fault=1, pll_rst=0.
  - Then pulse restart: fault=0, retry_count=0, state=RESET.
- Lock glitch in STABLE:
  - Stimulus: drop pll_locked for 1 cycle after 5 stable cycles.
  - Required response: returns to WAIT_LOCK with retry_count unchanged; after relock, release occurs a full 8 stable cycles later.
- Loss of lock in RUN:
  - Stimulus: drop pll_locked.
  - Required response: lock_lost pulses once, 3 cycles after the fall; core_reset_n=0 and pll_rst=1 on the same edge; full re-sequence follows.
- Simultaneous events:
  - restart on the same cycle lk falls in RUN -> RESET with no lock_lost pulse.
  - lk rises on the final timeout cycle -> STABLE with no retry increment.
- Async reset mid-STABLE:
  - Stimulus: assert reset_n low.
  - Required response: all outputs reach reset values without waiting for a clock edge; the sequence restarts from IDLE after release.
